// File: rtl/mmio_csr_bank.sv
// CCI-P MMIO register bank: DFH/AFU-ID, NUM_REGS 64-bit user registers and an
// MMIO data FIFO with sticky status, answered by a one-cycle registered response.
module mmio_csr_bank #(
  parameter int             NUM_REGS   = 8,
  parameter logic [15:0]    BASE_ADDR  = 16'h0020,
  parameter int             FIFO_DEPTH = 16,
  parameter logic [15:0]    FIFO_ADDR  = 16'h0080,
  parameter logic [127:0]   AFU_ID     = 128'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mmio_wr_valid,
  input  logic                     mmio_rd_valid,
  input  logic [15:0]              mmio_addr,
  input  logic [8:0]               mmio_tid,
  input  logic [63:0]              mmio_wdata,
  output logic                     rsp_valid,
  output logic [8:0]               rsp_tid,
  output logic [63:0]              rsp_data,
  output logic [64*NUM_REGS-1:0]   user_regs,
  output logic [NUM_REGS-1:0]      reg_wr_pulse
);

  localparam int             AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int             CW        = AW + 1;
  localparam logic [CW-1:0]  DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
  localparam logic [AW-1:0]  PTR_ONE   = AW'(1);
  localparam logic [15:0]    STAT_ADDR = FIFO_ADDR + 16'd2;
  localparam logic [63:0]    DFH       = {4'b0001, 8'b0, 4'b0, 7'b0, 1'b1, 24'b0, 4'b0, 12'b0};

  function automatic logic [15:0] reg_addr(input int idx);
    return BASE_ADDR + 16'(2 * idx);
  endfunction

  function automatic logic [63:0] pack_status(input logic [CW-1:0] cnt, input logic udf,
                                              input logic ovf, input logic full,
                                              input logic empty);
    return {48'b0, 8'(cnt), 4'b0, udf, ovf, full, empty};
  endfunction

  logic [63:0]          fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]        rd_ptr;
  logic [AW-1:0]        wr_ptr;
  logic [CW-1:0]        count;
  logic                 sticky_udf;
  logic                 sticky_ovf;
  logic [64*NUM_REGS-1:0] user_q;

  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 pop_req_p0;
  logic                 push_req_p0;
  logic                 w1c_p0;
  logic                 pop_ok_p0;
  logic                 push_ok_p0;
  logic                 udf_set_p0;
  logic                 ovf_set_p0;
  logic [NUM_REGS-1:0]  reg_we_p0;
  logic [63:0]          rd_data_p0;

  logic                 vld_p1;
  logic [8:0]           tid_p1;
  logic [63:0]          data_p1;
  logic [NUM_REGS-1:0]  pulse_p1;

  // p0: request decode against pre-write state
  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == DEPTH_C);
  assign pop_req_p0  = mmio_rd_valid && (mmio_addr == FIFO_ADDR);
  assign push_req_p0 = mmio_wr_valid && (mmio_addr == FIFO_ADDR);
  assign w1c_p0      = mmio_wr_valid && (mmio_addr == STAT_ADDR);
  assign pop_ok_p0   = pop_req_p0 && !fifo_empty;
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign push_ok_p0  = push_req_p0 && (!fifo_full || pop_ok_p0);
  assign udf_set_p0  = pop_req_p0 && fifo_empty;
  assign ovf_set_p0  = push_req_p0 && !push_ok_p0;

  always_comb begin
    reg_we_p0 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_we_p0[i] = mmio_wr_valid && (mmio_addr == reg_addr(i));
    end
  end

  always_comb begin
    rd_data_p0 = '0;
    if (mmio_addr == 16'h0000) begin
      rd_data_p0 = DFH;
    end else if (mmio_addr == 16'h0002) begin
      rd_data_p0 = AFU_ID[63:0];
    end else if (mmio_addr == 16'h0004) begin
      rd_data_p0 = AFU_ID[127:64];
    end else if (mmio_addr == FIFO_ADDR) begin
      rd_data_p0 = pop_ok_p0 ? fifo_mem[rd_ptr] : '0;
    end else if (mmio_addr == STAT_ADDR) begin
      rd_data_p0 = pack_status(count, sticky_udf, sticky_ovf, fifo_full, fifo_empty);
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (mmio_addr == reg_addr(i)) rd_data_p0 = user_q[64*i +: 64];
      end
    end
  end

  // p1: registered response, register file and FIFO state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      tid_p1   <= '0;
      data_p1  <= '0;
      pulse_p1 <= '0;
    end else begin
      vld_p1   <= mmio_rd_valid;
      pulse_p1 <= reg_we_p0;
      if (mmio_rd_valid) begin
        tid_p1  <= mmio_tid;
        data_p1 <= rd_data_p0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      user_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (reg_we_p0[i]) user_q[64*i +: 64] <= mmio_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      sticky_udf <= 1'b0;
      sticky_ovf <= 1'b0;
    end else begin
      if (pop_ok_p0)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push_ok_p0) wr_ptr <= wr_ptr + PTR_ONE;
      if (push_ok_p0 && !pop_ok_p0) begin
        count <= count + CNT_ONE;
      end else if (pop_ok_p0 && !push_ok_p0) begin
        count <= count - CNT_ONE;
      end
      // New events win over a same-cycle write-1-to-clear.
      sticky_udf <= (sticky_udf & ~(w1c_p0 & mmio_wdata[3])) | udf_set_p0;
      sticky_ovf <= (sticky_ovf & ~(w1c_p0 & mmio_wdata[2])) | ovf_set_p0;
    end
  end

  // Storage only; validity is tracked by the pointers, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_ok_p0) fifo_mem[wr_ptr] <= mmio_wdata;
  end

  assign rsp_valid    = vld_p1;
  assign rsp_tid      = tid_p1;
  assign rsp_data     = data_p1;
  assign user_regs    = user_q;
  assign reg_wr_pulse = pulse_p1;

endmodule
